// File: rtl/ldpc_pkg.sv
// Shared constants, FSM state type and helpers for the LDPC column datapath.
package ldpc_pkg;

  localparam int unsigned FP32_W  = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned COL_DEG = 3;

  localparam logic [FP32_W-1:0] FP32_MAX_POS = 32'h7F7F_FFFF;
  localparam logic [FP32_W-1:0] FP32_MAX_NEG = 32'hFF7F_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } col_state_e;

  // Leading-zero count of a 24-bit significand; returns 24 for an all-zero input.
  function automatic logic [4:0] lzc24(input logic [MAN_W:0] v);
    lzc24 = 5'd24;
    for (int unsigned i = 0; i <= MAN_W; i++) begin
      if (v[i]) lzc24 = 5'(MAN_W - i);
    end
  endfunction

endpackage

// File: rtl/column_extrinsic_distributor_fp32_add.sv
// Combinational fp32 adder: truncating alignment/normalisation, denormals as zero,
// underflow and exact cancellation to +0, overflow saturating to +/-max finite.
module fp32_add
  import ldpc_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] y
);

  logic               a_zero, b_zero, a_big;
  logic [FP32_W-1:0]  l, s;
  logic [EXP_W-1:0]   el, es, ediff;
  logic [MAN_W:0]     ml, ms, ms_al, dif, norm;
  logic [MAN_W+1:0]   sum;
  logic [4:0]         lz;

  always_comb begin
    y      = '0;
    sum    = '0;
    dif    = '0;
    norm   = '0;
    lz     = '0;
    a_zero = (a[FP32_W-2 -: EXP_W] == '0);
    b_zero = (b[FP32_W-2 -: EXP_W] == '0);
    // Exponent sits above the mantissa, so the magnitude field orders operands.
    a_big  = (a[FP32_W-2:0] >= b[FP32_W-2:0]);
    l      = a_big ? a : b;
    s      = a_big ? b : a;
    el     = l[FP32_W-2 -: EXP_W];
    es     = s[FP32_W-2 -: EXP_W];
    ml     = {1'b1, l[MAN_W-1:0]};
    ms     = {1'b1, s[MAN_W-1:0]};
    ediff  = el - es;
    ms_al  = (ediff > 8'd23) ? '0 : (ms >> ediff);

    if (a_zero && b_zero) begin
      y = '0;
    end else if (b_zero) begin
      y = a;
    end else if (a_zero) begin
      y = b;
    end else if (l[FP32_W-1] == s[FP32_W-1]) begin
      sum = {1'b0, ml} + {1'b0, ms_al};
      if (sum[MAN_W+1]) begin
        if (el >= 8'hFE) y = l[FP32_W-1] ? FP32_MAX_NEG : FP32_MAX_POS;
        else             y = {l[FP32_W-1], el + 8'd1, sum[MAN_W:1]};
      end else begin
        y = {l[FP32_W-1], el, sum[MAN_W-1:0]};
      end
    end else begin
      dif = ml - ms_al;
      if (dif != '0) begin
        lz   = lzc24(dif);
        norm = dif << lz;
        if ({3'b000, lz} < el) y = {l[FP32_W-1], el - {3'b000, lz}, norm[MAN_W-1:0]};
      end
    end
  end

endmodule

// File: rtl/column_extrinsic_distributor.sv
// Degree-3 column extrinsic messages q_i = S - r_i using one shared fp32 adder,
// stepped over the three edges by a small start/done FSM.
module column_extrinsic_distributor
  import ldpc_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [FP32_W-1:0] sum_in,
  input  logic [FP32_W-1:0] r1,
  input  logic [FP32_W-1:0] r2,
  input  logic [FP32_W-1:0] r3,
  output logic [FP32_W-1:0] q1,
  output logic [FP32_W-1:0] q2,
  output logic [FP32_W-1:0] q3,
  output logic              busy,
  output logic              done
);

  col_state_e         state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [FP32_W-1:0]  s_q, s_d;
  logic [FP32_W-1:0]  r_q [COL_DEG];
  logic [FP32_W-1:0]  r_d [COL_DEG];
  logic [FP32_W-1:0]  q_q [COL_DEG];
  logic [FP32_W-1:0]  q_d [COL_DEG];
  logic [FP32_W-1:0]  r_sel, diff;
  logic [COL_DEG-1:0] we;
  logic               accept;

  always_comb begin
    r_sel = r_q[2];
    case (idx_q)
      2'd0:    r_sel = r_q[0];
      2'd1:    r_sel = r_q[1];
      default: r_sel = r_q[2];
    endcase
  end

  fp32_add u_sub (
    .a (s_q),
    .b ({~r_sel[FP32_W-1], r_sel[FP32_W-2:0]}),
    .y (diff)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    s_d     = s_q;
    r_d     = r_q;
    q_d     = q_q;
    accept  = 1'b0;
    we      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        we    = 3'b001 << idx_q;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd2) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        accept  = start;
        state_d = start ? SUB : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      s_d    = sum_in;
      r_d[0] = r1;
      r_d[1] = r2;
      r_d[2] = r3;
      idx_d  = '0;
    end

    for (int unsigned i = 0; i < COL_DEG; i++) begin
      if (we[i]) q_d[i] = diff;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      idx_q   <= '0;
      s_q     <= '0;
      for (int unsigned i = 0; i < COL_DEG; i++) begin
        r_q[i] <= '0;
        q_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      r_q     <= r_d;
      q_q     <= q_d;
    end
  end

  assign q1   = q_q[0];
  assign q2   = q_q[1];
  assign q3   = q_q[2];
  assign busy = (state_q == SUB);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_column_extrinsic_distributor.sv
// Directed self-checking bench for column_extrinsic_distributor.
module tb_column_extrinsic_distributor;

  logic        clk, clr, start;
  logic [31:0] sum_in, r1, r2, r3;
  logic [31:0] q1, q2, q3;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  column_extrinsic_distributor dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .sum_in (sum_in),
    .r1     (r1),
    .r2     (r2),
    .r3     (r3),
    .q1     (q1),
    .q2     (q2),
    .q3     (q3),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
    sum_in = s; r1 = a; r2 = b; r3 = c;
  endtask

  // Drives one start pulse; returns just after acceptance edge k.
  task automatic launch(input logic [31:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
    set_ops(s, a, b, c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0;
    set_ops('0, '0, '0, '0);
    #3;
    checks++; if (q1 !== 32'h0)  begin errors++; $display("FAIL reset_q1 got %h want %h", q1, 32'h0); end
    checks++; if (q2 !== 32'h0)  begin errors++; $display("FAIL reset_q2 got %h want %h", q2, 32'h0); end
    checks++; if (q3 !== 32'h0)  begin errors++; $display("FAIL reset_q3 got %h want %h", q3, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    launch(32'h40C00000, 32'h3F800000, 32'h40000000, 32'h40400000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_k got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_k got %b want 0", done); end
    tick();
    checks++; if (q1 !== 32'h40A00000) begin errors++; $display("FAIL basic_q1 got %h want %h", q1, 32'h40A00000); end
    tick();
    checks++; if (q2 !== 32'h40800000) begin errors++; $display("FAIL basic_q2 got %h want %h", q2, 32'h40800000); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_k2 got %b want 0", done); end
    tick();
    checks++; if (q3 !== 32'h40400000) begin errors++; $display("FAIL basic_q3 got %h want %h", q3, 32'h40400000); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_k3 got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_k3 got %b want 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_k4 got %b want 0", done); end
  endtask

  task automatic test_sign();
    launch(32'h3F800000, 32'hC0000000, 32'h40400000, 32'h3F800000);
    tick(); tick(); tick();
    checks++; if (q1 !== 32'h40400000) begin errors++; $display("FAIL sign_q1 got %h want %h", q1, 32'h40400000); end
    checks++; if (q2 !== 32'hC0000000) begin errors++; $display("FAIL sign_q2 got %h want %h", q2, 32'hC0000000); end
    checks++; if (q3 !== 32'h00000000) begin errors++; $display("FAIL sign_q3_zero got %h want %h", q3, 32'h0); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sign_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_start_busy();
    int dcnt;
    dcnt = 0;
    launch(32'h40C00000, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_ops(32'h41000000, 32'h40800000, 32'h40A00000, 32'h40C00000);
    start = 1'b1;
    tick();
    checks++; if (q1 !== 32'h40A00000) begin errors++; $display("FAIL busy_q1 got %h want %h", q1, 32'h40A00000); end
    tick();
    start = 1'b0;
    checks++; if (q2 !== 32'h40800000) begin errors++; $display("FAIL busy_q2 got %h want %h", q2, 32'h40800000); end
    tick();
    if (done) dcnt++;
    checks++; if (q3 !== 32'h40400000) begin errors++; $display("FAIL busy_q3 got %h want %h", q3, 32'h40400000); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dcnt++;
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", dcnt); end
  endtask

  task automatic test_back_to_back();
    set_ops(32'h40C00000, 32'h3F800000, 32'h40000000, 32'h40400000);
    start = 1'b1;
    tick();
    set_ops(32'h41000000, 32'h3F800000, 32'h40000000, 32'h40400000);
    tick();
    checks++; if (q1 !== 32'h40A00000) begin errors++; $display("FAIL b2b_first_q1 got %h want %h", q1, 32'h40A00000); end
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", done); end
    checks++; if (q3 !== 32'h40400000) begin errors++; $display("FAIL b2b_first_q3 got %h want %h", q3, 32'h40400000); end
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_rebusy got %b want 1", busy); end
    checks++; if (q1 !== 32'h40A00000) begin errors++; $display("FAIL b2b_q1_hold got %h want %h", q1, 32'h40A00000); end
    tick();
    checks++; if (q1 !== 32'h40E00000) begin errors++; $display("FAIL b2b_second_q1 got %h want %h", q1, 32'h40E00000); end
    tick();
    checks++; if (q2 !== 32'h40C00000) begin errors++; $display("FAIL b2b_second_q2 got %h want %h", q2, 32'h40C00000); end
    tick();
    checks++; if (q3 !== 32'h40A00000) begin errors++; $display("FAIL b2b_second_q3 got %h want %h", q3, 32'h40A00000); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_end got %b want 0", done); end
  endtask

  task automatic test_reset_mid();
    launch(32'h40C00000, 32'h3F800000, 32'h40000000, 32'h40400000);
    tick();
    checks++; if (q1 !== 32'h40A00000) begin errors++; $display("FAIL mid_q1_pre got %h want %h", q1, 32'h40A00000); end
    #2 clr = 1'b1;
    #1;
    checks++; if (q1 !== 32'h0)  begin errors++; $display("FAIL mid_q1 got %h want %h", q1, 32'h0); end
    checks++; if (q2 !== 32'h0)  begin errors++; $display("FAIL mid_q2 got %h want %h", q2, 32'h0); end
    checks++; if (q3 !== 32'h0)  begin errors++; $display("FAIL mid_q3 got %h want %h", q3, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
    tick(); tick();
    clr = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got %b want 0", busy); end
    launch(32'h41000000, 32'h3F800000, 32'h40000000, 32'h40400000);
    tick();
    checks++; if (q1 !== 32'h40E00000) begin errors++; $display("FAIL mid_after_q1 got %h want %h", q1, 32'h40E00000); end
    tick(); tick();
    checks++; if (q3 !== 32'h40A00000) begin errors++; $display("FAIL mid_after_q3 got %h want %h", q3, 32'h40A00000); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_after_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_saturation();
    launch(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h3F800000, 32'h7F7FFFFF);
    tick();
    checks++; if (q1 !== 32'h7F7FFFFF) begin errors++; $display("FAIL sat_q1 got %h want %h", q1, 32'h7F7FFFFF); end
    tick();
    checks++; if (q2 !== 32'h7F7FFFFF) begin errors++; $display("FAIL sat_q2 got %h want %h", q2, 32'h7F7FFFFF); end
    tick();
    checks++; if (q3 !== 32'h00000000) begin errors++; $display("FAIL sat_q3 got %h want %h", q3, 32'h0); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done got %b want 1", done); end
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
